pb_debounce_bank: RTL

Parametrised, multi-channel push-button debouncer. It replaces the single-channel three-flop debouncer with per-channel synchronisers, a shared sample-tick prescaler, programmable stability count, input polarity select, and one-cycle press/release strobes. It sits between raw board buttons and the capture/config control logic, for example for camera register-reload or mode-select keys. Everything runs in the system clock domain: no derived clocks.

---
 rtl/pb_debounce_bank.sv | 117 +++++++++++
 1 files changed

// File: rtl/pb_debounce_bank.sv
// Multi-channel push-button debouncer.
// Each channel has a 2-flop synchroniser, optional polarity inversion
// and a stability counter. A shared prescaler sets the sample rate.
// Ports:
//   clk     : system clock, all logic on rising edge
//   rst     : synchronous active-high reset
//   pb_in   : raw asynchronous button levels [N]
//   pb_out  : debounced level, 1 = pressed [N]
//   pb_rise : one-cycle strobe on accepted press [N]
//   pb_fall : one-cycle strobe on accepted release [N]
//   tick    : sample strobe shared by all channels
module pb_debounce_bank #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 50,
  parameter int STABLE_TICKS = 4,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pb_in,
  output logic [N-1:0] pb_out,
  output logic [N-1:0] pb_rise,
  output logic [N-1:0] pb_fall,
  output logic         tick
);

  localparam int DW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);

  localparam logic [DW-1:0] DIV_MAX =
    DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(STABLE_TICKS - 1);
  localparam logic [N-1:0] IDLE =
    {N{ACTIVE_LOW}};

  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;

  logic [N-1:0]  sync1_q, sync2_q;
  logic [N-1:0]  s;

  logic [N-1:0]  out_q, out_d;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // tick is registered from the next count so
  // it is high while div_q sits at DIV_MAX.
  always_comb begin
    div_d  = (div_q == DIV_MAX) ?
             '0 : div_q + 1'b1;
    tick_d = (div_d == DIV_MAX);
  end

  assign s = sync2_q ^ IDLE;

  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (tick_q) begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i]  = '0;
          out_d[i]  = s[i];
          rise_d[i] = s[i];
          fall_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Sync flops reset to the raw idle level so
  // a held button after reset looks like a
  // fresh press rather than a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= IDLE;
      sync2_q <= IDLE;
      out_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      sync1_q <= pb_in;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pb_out  = out_q;
  assign pb_rise = rise_q;
  assign pb_fall = fall_q;
  assign tick    = tick_q;

endmodule
